byte_serial_add_sequencer: RTL
==============================

# byte_serial_add_sequencer

Multi-cycle controller that adds wide operands using one shared `full_adder_8bit` instance, one byte slice per clock. The carry is registered between slices, and the partial sum is assembled in a shift register. A single-entry request/response handshake with valid/ready on each side wraps the whole operation. The block sits between a wide-operand producer and its consumer, trading latency for a single 8-bit adder in place of a wide one.

## Interface
Parameters:
- `NBYTES`, default 4: operand width in bytes; legal range 1..16; datapath width `W = 8*NBYTES`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: request present.
- `in_ready`, output, 1: block can accept a request.
- `a`, input, W: operand A, sampled at accept.
- `b`, input, W: operand B, sampled at accept.
- `cin`, input, 1: carry-in, sampled at accept.
- `op`, input, 1: 0 = add, 1 = subtract. Present only with `SERIAL_SUB_EN`.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer accepts the result.
- `sum`, output, W: result.
- `cout`, output, 1: final carry-out.
- `ovf`, output, 1: two's-complement signed overflow.

## Operation
- FSM with three states: IDLE, RUN, DONE. Reset state is IDLE.
- `in_ready` = (state == IDLE) && !rst.
- `out_valid` = (state == DONE).
- **IDLE:** on `in_valid && in_ready`:
  - load A and B into shift registers;
  - load the carry register with `cin` (or 1 for subtract);
  - clear the byte counter;
  - go to RUN.
- **RUN:** each cycle the shared adder computes `a_sh[7:0] + b_eff[7:0] + carry_q`.
  - The sum byte shifts into `sum` from the MSB end.
  - `carry_q` takes the adder `cout`.
  - A and B shift right by 8; the counter increments.
  - After slice `NBYTES-1`, go to DONE.
- **Overflow capture:** on the last slice, `ovf` is captured as (`a[W-1] == b_eff[W-1]`) && (`s[7] != a[W-1]`).
- **DONE:** `sum`, `cout` and `ovf` hold stable. On `out_ready`, go to IDLE.
- Width rules: all arithmetic is modulo 2^W, and `cout` is bit W of the full sum.
- Only one operation is in flight. A new request is never accepted in RUN or DONE, and `in_valid` is ignored there.
- Output values are retained after returning to IDLE, until the next operation overwrites them slice by slice. `out_valid` is the only qualifier.
- **Reset:** `rst` takes effect at any state, including mid-RUN; the partial result is discarded.
- Reset values: state = IDLE, `sum` = 0, `cout` = 0, `ovf` = 0, `out_valid` = 0, carry and counter = 0.
- `in_ready` reads 0 while `rst` is high and 1 in the cycle after reset deasserts.

## Timing
- Accept handshake at edge E0.
- RUN occupies the cycles after edges E0 .. E0+NBYTES-1.
- `out_valid` rises after edge E0+NBYTES: latency NBYTES+1 cycles from accept to result.
- Output handshake at edge Ek returns to IDLE, and `in_ready` is high in the following cycle.
- Minimum initiation interval is NBYTES+2 cycles.
- `NBYTES` = 1: a single RUN cycle, latency 2.
- Backpressure: DONE persists indefinitely while `out_ready` = 0, with no output change.
- `out_ready` high outside DONE has no effect.
- The combinational path per cycle is limited to one 8-bit adder plus muxing.

## Configuration
- Macro: `SERIAL_SUB_EN`.
- **Defined:**
  - `op` port exists.
  - When `op` = 1 at accept, B is bitwise inverted and the carry register is loaded with 1 (`cin` ignored), giving A − B.
  - `cout` = 1 means no borrow.
  - `ovf` uses the inverted B MSB.
- **Undefined:**
  - No `op` port; B passes uninverted and the block always adds with `cin`.

## Test plan
NBYTES = 4 unless noted.
- **Carry ripple:** a=0xFFFFFFFF, b=0x00000001, cin=0 → `sum`=0x00000000, `cout`=1, `ovf`=0, with `out_valid` first high 5 cycles after accept.
- **Signed overflow and cin:**
  - a=0x7FFFFFFF, b=0x00000000, cin=1 → `sum`=0x80000000, `cout`=0, `ovf`=1;
  - a=0x12345678, b=0x11111111, cin=0 → `sum`=0x23456789, `ovf`=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE with `in_valid`=1 → `sum`/`cout` unchanged and `in_ready`=0 throughout. Then `out_ready`=1 for one cycle → `in_ready`=1 next cycle and the pending request is accepted.
- **Reset mid-RUN:** assert `rst` for 1 cycle after slice 1 → `out_valid` never asserts for that request; `sum`=0 and `in_ready`=1 after reset. A new request 0x00000002+0x00000003 → 0x00000005.
- **SERIAL_SUB_EN:**
  - op=1, a=5, b=7 → `sum`=0xFFFFFFFE, `cout`=0;
  - op=1, a=0x80000000, b=1 → `sum`=0x7FFFFFFF, `ovf`=1, `cout`=1.
- **NBYTES=1:** a=0xF0, b=0x20, cin=1 → `sum`=0x11, `cout`=1, latency 2. Back-to-back requests are accepted every 3 cycles with `out_ready` tied high.

Source files
------------

// File: rtl/byte_serial_add_sequencer.sv
// Byte-serial wide adder: one shared 8-bit adder processes one byte slice per clock.
// Optional subtract mode (op port, A - B) is enabled by defining SERIAL_SUB_EN.

module full_adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    assign {cout, s} = 9'(a) + 9'(b) + 9'(cin);
endmodule

module byte_serial_add_sequencer #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
`ifdef SERIAL_SUB_EN
    input  logic                op,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [W-1:0]    a_sh;
    logic [W-1:0]    b_sh;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic            accept_c;
    logic            last_c;
    logic            sub_c;
    logic [7:0]      slice_s_c;
    logic            slice_co_c;

`ifdef SERIAL_SUB_EN
    assign sub_c = op;
`else
    assign sub_c = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign accept_c  = in_valid && in_ready;
    assign last_c    = (cnt_q == CW'(NBYTES - 1));

    full_adder_8bit u_adder (
        .a    (a_sh[7:0]),
        .b    (b_sh[7:0]),
        .cin  (carry_q),
        .s    (slice_s_c),
        .cout (slice_co_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slice datapath: operands shift right, result bytes enter sum from the MSB end.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (state_q == IDLE) begin
            if (accept_c) begin
                a_sh    <= a;
                b_sh    <= sub_c ? ~b : b;
                carry_q <= sub_c ? 1'b1 : cin;
                cnt_q   <= '0;
            end
        end else if (state_q == RUN) begin
            sum     <= W'({slice_s_c, sum} >> 8);
            carry_q <= slice_co_c;
            a_sh    <= a_sh >> 8;
            b_sh    <= b_sh >> 8;
            cnt_q   <= cnt_q + CW'(1);
            // On the last slice the low byte of the shifters holds the operand MSBs.
            if (last_c) begin
                cout <= slice_co_c;
                ovf  <= (a_sh[7] == b_sh[7]) && (slice_s_c[7] != a_sh[7]);
            end
        end
    end

endmodule
